// File: rtl/scan_hex_pkg.sv
// -----------------------------------------------------------------------------
// scan_hex_pkg
// Shared definitions for the scan_hex receive-side hex parser.
//   - state_t       : FSM state encoding (IDLE, RECV, PROC, DONE)
//   - char_class_t  : classification of a received character in word mode
//   - ASC_*         : ASCII constants for separators, terminators and editing keys
//   - MODE_*        : encoding of type_rx (raw byte vs. hex word)
//   - classify()    : maps a character plus its hex-digit flag to a char_class_t
// -----------------------------------------------------------------------------
package scan_hex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PROC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CC_HEX  = 3'd0,
    CC_SEP  = 3'd1,
    CC_TERM = 3'd2,
    CC_BS   = 3'd3,
    CC_ILL  = 3'd4
  } char_class_t;

  localparam logic [7:0] ASC_CR         = 8'h0D;
  localparam logic [7:0] ASC_SP         = 8'h20;
  localparam logic [7:0] ASC_DASH       = 8'h2D;
  localparam logic [7:0] ASC_UNDERSCORE = 8'h5F;
  localparam logic [7:0] ASC_BS         = 8'h08;
  localparam logic [7:0] ASC_DEL        = 8'h7F;

  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  // Hex digits win over everything else; BS/DEL are always reported as
  // CC_BS and the FSM decides whether editing is supported in this build.
  function automatic char_class_t classify(input logic [7:0] c, input logic is_hex);
    char_class_t cc;
    if (is_hex) begin
      cc = CC_HEX;
    end else if ((c == ASC_DASH) || (c == ASC_UNDERSCORE)) begin
      cc = CC_SEP;
    end else if ((c == ASC_CR) || (c == ASC_SP)) begin
      cc = CC_TERM;
    end else if ((c == ASC_BS) || (c == ASC_DEL)) begin
      cc = CC_BS;
    end else begin
      cc = CC_ILL;
    end
    return cc;
  endfunction

endpackage

// File: rtl/scan_hex_c2h.sv
// -----------------------------------------------------------------------------
// scan_hex_c2h
// Combinational ASCII-to-nibble converter, the inverse of the print path's H2C.
// Accepts '0'-'9', 'A'-'F' and 'a'-'f'.
// Ports:
//   i_asc    [7:0]  ASCII character
//   o_hex    [3:0]  nibble value (0 when not a hex digit)
//   o_is_hex        1 when i_asc is a hex digit
// -----------------------------------------------------------------------------
module scan_hex_c2h
  import scan_hex_pkg::*;
(
  input  logic [7:0] i_asc,
  output logic [3:0] o_hex,
  output logic       o_is_hex
);

  // Decode digit ranges; letters map via low nibble + 9 ('A'/'a' low nibble is 1).
  always_comb begin
    o_hex    = 4'h0;
    o_is_hex = 1'b0;
    if ((i_asc >= 8'h30) && (i_asc <= 8'h39)) begin
      o_hex    = i_asc[3:0];
      o_is_hex = 1'b1;
    end else if ((i_asc >= 8'h41) && (i_asc <= 8'h46)) begin
      o_hex    = i_asc[3:0] + 4'h9;
      o_is_hex = 1'b1;
    end else if ((i_asc >= 8'h61) && (i_asc <= 8'h66)) begin
      o_hex    = i_asc[3:0] + 4'h9;
      o_is_hex = 1'b1;
    end else begin
      o_hex    = 4'h0;
      o_is_hex = 1'b0;
    end
  end

endmodule

// File: rtl/scan_hex.sv
// -----------------------------------------------------------------------------
// scan_hex
// Receive-side hex scanner for the debug unit. Pulls ASCII characters from the
// UART receiver (valid/ready) and returns either one raw byte or a hex word to
// the command controller over a 4-phase req/ack handshake.
//
// Build option: define SCAN_BACKSPACE_EN to let BS (0x08) / DEL (0x7F) delete
// the most recent digit in word mode; without it they are illegal characters.
//
// Parameters:
//   MAX_DIGITS  hex digits retained for a word (older digits shift out the top)
//   DW          result width, must be 4*MAX_DIGITS
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset
//   d_rx     ASCII character from the UART receiver
//   vld_rx   d_rx valid
//   rdy_rx   ready; a character transfers when vld_rx && rdy_rx
//   req_rx   controller request to scan one item
//   type_rx  0 = raw byte, 1 = hex word (sampled when the request starts)
//   ack_rx   result valid, held until req_rx falls
//   din_rx   parsed result, held until the next result
//   err_rx   an illegal character was seen in the word just returned
// -----------------------------------------------------------------------------
module scan_hex
  import scan_hex_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    d_rx,
  input  logic          vld_rx,
  output logic          rdy_rx,
  input  logic          req_rx,
  input  logic          type_rx,
  output logic          ack_rx,
  output logic [DW-1:0] din_rx,
  output logic          err_rx
);

  localparam int              CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  state_t          r_state;
  logic            r_type;
  logic [7:0]      r_char;
  logic [DW-1:0]   r_sr;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            r_rdy;
  logic            r_ack;
  logic [DW-1:0]   r_din;
  logic            r_err_out;

  logic [3:0]      w_nib;
  logic            w_is_hex;
  char_class_t     w_class;

  scan_hex_c2h u_c2h (
    .i_asc    (r_char),
    .o_hex    (w_nib),
    .o_is_hex (w_is_hex)
  );

  assign w_class = classify(r_char, w_is_hex);

  // Main control FSM: request handshake, character intake and word assembly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_type    <= MODE_BYTE;
      r_char    <= 8'h00;
      r_sr      <= {DW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_err     <= 1'b0;
      r_rdy     <= 1'b0;
      r_ack     <= 1'b0;
      r_din     <= {DW{1'b0}};
      r_err_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_rx && !r_ack) begin
            r_type  <= type_rx;
            r_sr    <= {DW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_err   <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= ST_RECV;
          end else begin
            r_rdy   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        // Abort has priority over a concurrent character: rdy_rx was
        // already high, but the character is simply not captured.
        ST_RECV: begin
          if (!req_rx) begin
            r_rdy   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (vld_rx && r_rdy) begin
            r_char  <= d_rx;
            r_rdy   <= 1'b0;
            r_state <= ST_PROC;
          end else begin
            r_state <= ST_RECV;
          end
        end

        ST_PROC: begin
          if (!req_rx) begin
            r_rdy   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_type == MODE_BYTE) begin
            r_din   <= {{(DW-8){1'b0}}, r_char};
            r_state <= ST_DONE;
          end else begin
            case (w_class)
              CC_HEX: begin
                r_sr    <= {r_sr[DW-5:0], w_nib};
                if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + CNT_ONE;
                end else begin
                  r_cnt <= r_cnt;
                end
                r_rdy   <= 1'b1;
                r_state <= ST_RECV;
              end
              CC_SEP: begin
                r_rdy   <= 1'b1;
                r_state <= ST_RECV;
              end
              // A terminator before any digit is leading whitespace.
              CC_TERM: begin
                if (r_cnt == {CW{1'b0}}) begin
                  r_rdy   <= 1'b1;
                  r_state <= ST_RECV;
                end else begin
                  r_din   <= r_sr;
                  r_state <= ST_DONE;
                end
              end
              CC_BS: begin
`ifdef SCAN_BACKSPACE_EN
                if (r_cnt != {CW{1'b0}}) begin
                  r_sr  <= {4'h0, r_sr[DW-1:4]};
                  r_cnt <= r_cnt - CNT_ONE;
                end else begin
                  r_cnt <= r_cnt;
                end
`else
                r_err <= 1'b1;
`endif
                r_rdy   <= 1'b1;
                r_state <= ST_RECV;
              end
              default: begin
                r_err   <= 1'b1;
                r_rdy   <= 1'b1;
                r_state <= ST_RECV;
              end
            endcase
          end
        end

        ST_DONE: begin
          if (!req_rx) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_ack     <= 1'b1;
            r_err_out <= r_err;
            r_state   <= ST_DONE;
          end
        end

        default: begin
          r_rdy   <= 1'b0;
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdy_rx = r_rdy;
  assign ack_rx = r_ack;
  assign din_rx = r_din;
  assign err_rx = r_err_out;

endmodule

// File: tb/tb_scan_hex.sv
module tb_scan_hex;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  d_rx;
  logic        vld_rx;
  logic        rdy_rx;
  logic        req_rx;
  logic        type_rx;
  logic        ack_rx;
  logic [31:0] din_rx;
  logic        err_rx;

  int n_pass   = 0;
  int n_checks = 0;

  logic [31:0] exp_din = 32'h0;
  logic        exp_err = 1'b0;
  bit          ack_ok  = 1'b0;
  bit          chk_en  = 1'b0;
  bit          hs_prev = 1'b0;
  bit          req_prev = 1'b0;

  scan_hex #(.MAX_DIGITS(8), .DW(32)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .req_rx  (req_rx),
    .type_rx (type_rx),
    .ack_rx  (ack_rx),
    .din_rx  (din_rx),
    .err_rx  (err_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req_v);
  endtask

  // Reference nibble value of an ASCII character, -1 if not a hex digit.
  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Word-mode reference: value of the last 8 digits and whether anything illegal appeared.
  function automatic void model_word(input string s, output logic [31:0] v, output logic e);
    int cnt = 0;
    v = 32'h0;
    e = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      int n;
      c = s[i];
      n = hexval(c);
      if (n >= 0) begin
        v = (v * 32'd16) + 32'(n);
        if (cnt < 8) cnt++;
      end else if (c == 8'h2D || c == 8'h5F) begin
      end else if (c == 8'h0D || c == 8'h20) begin
        if (cnt != 0) break;
`ifdef SCAN_BACKSPACE_EN
      end else if (c == 8'h08 || c == 8'h7F) begin
        if (cnt > 0) begin
          v = v / 32'd16;
          cnt--;
        end
`endif
      end else begin
        e = 1'b1;
      end
    end
  endfunction

  // Per-cycle checks against the model and the handshake rules.
  always @(negedge clk) begin
    if (chk_en && rstn) begin
      if (vld_rx && rdy_rx) check("no_back_to_back", 32'(hs_prev), 32'd0);
      if (!req_rx && !req_prev) begin
        check("idle_rdy", 32'(rdy_rx), 32'd0);
        check("idle_ack", 32'(ack_rx), 32'd0);
      end
      if (ack_rx) begin
        check("ack_expected", 32'(ack_ok), 32'd1);
        check("model_din", din_rx, exp_din);
        check("model_err", 32'(err_rx), 32'(exp_err));
      end
      hs_prev  = vld_rx && rdy_rx;
      req_prev = req_rx;
    end
  end

  task automatic start_req(input logic typ);
    @(posedge clk); #1;
    req_rx  = 1'b1;
    type_rx = typ;
  endtask

  task automatic send_char(input logic [7:0] c);
    bit hit = 1'b0;
    d_rx   = c;
    vld_rx = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (rdy_rx) hit = 1'b1;
    end
    if (!hit) check("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    vld_rx = 1'b0;
  endtask

  // Called right after the final handshake edge: checks latency, result and ack release.
  task automatic finish_item(input logic [31:0] lit_din, input logic lit_err);
    @(negedge clk);
    @(negedge clk);
    check("ack_early", 32'(ack_rx), 32'd0);
    @(negedge clk);
    check("ack_latency", 32'(ack_rx), 32'd1);
    check("lit_din", din_rx, lit_din);
    check("lit_err", 32'(err_rx), 32'(lit_err));
    @(posedge clk); #1;
    req_rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ack_drop", 32'(ack_rx), 32'd0);
    ack_ok = 1'b0;
  endtask

  task automatic run_byte(input logic [7:0] c, input logic [31:0] lit_din);
    exp_din = {24'h0, c};
    exp_err = 1'b0;
    start_req(1'b0);
    @(posedge clk); #1;
    type_rx = 1'b1;
    ack_ok = 1'b1;
    send_char(c);
    finish_item(lit_din, 1'b0);
  endtask

  task automatic run_word(input string s, input logic [31:0] lit_din, input logic lit_err);
    logic [31:0] v;
    logic        e;
    model_word(s, v, e);
    exp_din = v;
    exp_err = e;
    start_req(1'b1);
    for (int i = 0; i < s.len() - 1; i++) send_char(s[i]);
    ack_ok = 1'b1;
    send_char(s[s.len()-1]);
    finish_item(lit_din, lit_err);
  endtask

  initial begin
    rstn    = 1'b0;
    d_rx    = 8'h00;
    vld_rx  = 1'b0;
    req_rx  = 1'b0;
    type_rx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(rdy_rx), 32'd0);
    check("rst_ack", 32'(ack_rx), 32'd0);
    check("rst_din", din_rx, 32'd0);
    check("rst_err", 32'(err_rx), 32'd0);
    @(posedge clk); #1;
    rstn   = 1'b1;
    chk_en = 1'b1;

    run_byte(8'h5A, 32'h0000005A);
    run_word("1234-abCD\015", 32'h1234ABCD, 1'b0);
    run_word("  7F ", 32'h0000007F, 1'b0);
    run_word("123456789\015", 32'h23456789, 1'b0);
    run_word("12G3\015", 32'h00000123, 1'b1);

    // Abort mid-word: no ack, ready drops, result unchanged.
    start_req(1'b1);
    send_char("A");
    send_char("B");
    @(posedge clk); #1;
    req_rx = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rdy", 32'(rdy_rx), 32'd0);
    check("abort_ack", 32'(ack_rx), 32'd0);
    check("abort_din", din_rx, 32'h00000123);

    run_word("5 ", 32'h00000005, 1'b0);

`ifdef SCAN_BACKSPACE_EN
    run_word("12\0103\015", 32'h00000013, 1'b0);
`else
    run_word("12\0103\015", 32'h00000123, 1'b1);
`endif

    // Asynchronous reset in the middle of a word.
    start_req(1'b1);
    send_char("1");
    send_char("2");
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy_rx), 32'd0);
    check("midrst_ack", 32'(ack_rx), 32'd0);
    check("midrst_din", din_rx, 32'd0);
    check("midrst_err", 32'(err_rx), 32'd0);
    req_rx = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    run_byte(8'h0D, 32'h0000000D);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
